// File: rtl/itgnet_frame_sched_if.sv
// Source/network-side bundle of the itgnet frame scheduler.
// Source handshake: a beat transfers on a rising clock edge where src_valid and
// src_ready are both 1; src_ready never depends on src_valid.
interface itgnet_frame_sched_if #(
  parameter int V_BITW = 3,
  parameter int H_BITW = 3
);
  logic              src_valid;
  logic              src_ready;
  logic              net_in_enable;
  logic [V_BITW-1:0] net_in_vcnt;
  logic [H_BITW-1:0] net_in_hcnt;
  logic              net_pad;
  logic              net_out_enable;

  modport master (
    input  src_valid,
    input  net_out_enable,
    output src_ready,
    output net_in_enable,
    output net_in_vcnt,
    output net_in_hcnt,
    output net_pad
  );

  modport slave (
    output src_valid,
    output net_out_enable,
    input  src_ready,
    input  net_in_enable,
    input  net_in_vcnt,
    input  net_in_hcnt,
    input  net_pad
  );
endinterface

// File: rtl/itgnet_frame_sched.sv
// Frame sequencer for the itgnet CNN: streams one raster window, then pads until all outputs emerge.
// Optional stall performance counter enabled by defining ITGNET_SCHED_PERF_EN.
module itgnet_frame_sched #(
  parameter  int W_HEIGHT  = 8,
  parameter  int W_WIDTH   = 8,
  parameter  int DRAIN_MAX = 1024,
  localparam int V_BITW    = (W_HEIGHT > 1) ? $clog2(W_HEIGHT) : 1,
  localparam int H_BITW    = (W_WIDTH > 1) ? $clog2(W_WIDTH) : 1,
  localparam int N_PIX     = W_HEIGHT * W_WIDTH,
  localparam int C_BITW    = $clog2(N_PIX + 1),
  localparam int D_BITW    = $clog2(DRAIN_MAX + 1)
) (
  input  logic                clock,
  input  logic                n_rst,
  input  logic                start,
  input  logic                abort,
  output logic                busy,
  output logic                done,
  output logic                drain_err,
  output logic [C_BITW-1:0]   out_count,
  output logic [31:0]         stall_cycles,
  output logic [1:0]          state_dbg,
  itgnet_frame_sched_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [V_BITW-1:0] vcnt;
  logic [H_BITW-1:0] hcnt;
  logic [V_BITW-1:0] next_v;
  logic [H_BITW-1:0] next_h;
  logic [D_BITW-1:0] drain_cnt;
  logic              last_col;
  logic              last_row;
  logic              accept;
  logic              out_inc;
  logic              out_full;

  assign bus.src_ready = (state == S_STREAM);
  assign busy          = (state == S_STREAM) || (state == S_FLUSH);
  assign state_dbg     = state;
  assign accept        = bus.src_valid & bus.src_ready;
  assign last_col      = (hcnt == H_BITW'(W_WIDTH - 1));
  assign last_row      = (vcnt == V_BITW'(W_HEIGHT - 1));
  assign out_full      = (out_count == C_BITW'(N_PIX));
  assign out_inc       = bus.net_out_enable & busy & ~out_full;

  // Raster successor of the current position, shared by stream and pad beats.
  always_comb begin
    next_h = hcnt + 1'b1;
    next_v = vcnt;
    if (last_col) begin
      next_h = '0;
      next_v = last_row ? '0 : vcnt + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!n_rst) begin
      state             <= S_IDLE;
      vcnt              <= '0;
      hcnt              <= '0;
      drain_cnt         <= '0;
      out_count         <= '0;
      drain_err         <= 1'b0;
      done              <= 1'b0;
      bus.net_in_enable <= 1'b0;
      bus.net_in_vcnt   <= '0;
      bus.net_in_hcnt   <= '0;
      bus.net_pad       <= 1'b0;
    end else if (abort) begin
      // Cancel keeps drain_err and out_count so software can inspect the partial frame.
      state             <= S_IDLE;
      vcnt              <= '0;
      hcnt              <= '0;
      drain_cnt         <= '0;
      done              <= 1'b0;
      bus.net_in_enable <= 1'b0;
      bus.net_in_vcnt   <= '0;
      bus.net_in_hcnt   <= '0;
      bus.net_pad       <= 1'b0;
    end else begin
      if (out_inc) out_count <= out_count + 1'b1;
      case (state)
        S_IDLE: begin
          done              <= 1'b0;
          bus.net_in_enable <= 1'b0;
          bus.net_pad       <= 1'b0;
          if (start) begin
            state     <= S_STREAM;
            vcnt      <= '0;
            hcnt      <= '0;
            drain_cnt <= '0;
            out_count <= '0;
            drain_err <= 1'b0;
          end
        end
        S_STREAM: begin
          bus.net_in_enable <= accept;
          bus.net_pad       <= 1'b0;
          if (accept) begin
            bus.net_in_vcnt <= vcnt;
            bus.net_in_hcnt <= hcnt;
            vcnt            <= next_v;
            hcnt            <= next_h;
            if (last_col && last_row) state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          // Completion is tested first so it wins over a simultaneous drain timeout.
          if (out_full || (drain_cnt == D_BITW'(DRAIN_MAX))) begin
            state             <= S_DONE;
            done              <= 1'b1;
            drain_err         <= ~out_full;
            bus.net_in_enable <= 1'b0;
            bus.net_pad       <= 1'b0;
          end else begin
            bus.net_in_enable <= 1'b1;
            bus.net_pad       <= 1'b1;
            bus.net_in_vcnt   <= vcnt;
            bus.net_in_hcnt   <= hcnt;
            vcnt              <= next_v;
            hcnt              <= next_h;
            drain_cnt         <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state             <= S_IDLE;
          done              <= 1'b0;
          bus.net_in_enable <= 1'b0;
          bus.net_pad       <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef ITGNET_SCHED_PERF_EN
  always_ff @(posedge clock) begin
    if (!n_rst) begin
      stall_cycles <= '0;
    end else if ((state == S_IDLE) && start && !abort) begin
      stall_cycles <= '0;
    end else if ((state == S_STREAM) && !bus.src_valid && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`else
  assign stall_cycles = '0;
`endif

endmodule
